// File: rtl/lorenz_step_ctrl.sv
// Run controller for a Lorenz-attractor integrator: sequences load/step pulses,
// decimates and buffers samples with a valid/ready handshake. Optional bound check: LORENZ_CTRL_BOUND_CHECK_EN.
module lorenz_step_ctrl #(
  parameter int unsigned             WIDTH = 27,
  parameter int unsigned             CNT_W = 32,
  parameter int unsigned             DEC_W = 16,
  parameter logic signed [WIDTH-1:0] BOUND = 27'sh1F00000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [CNT_W-1:0]        num_steps,
  input  logic [DEC_W-1:0]        decim,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic                    int_load,
  output logic                    int_step,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_x,
  output logic signed [WIDTH-1:0] out_y,
  output logic signed [WIDTH-1:0] out_z,
  output logic [CNT_W-1:0]        out_idx,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_CAPT = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // A non-positive limit would flag every sample as divergent.
  if (BOUND <= 0) begin : g_bad_bound
    $error("lorenz_step_ctrl: BOUND must be positive");
  end

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] step_cnt;
  logic [CNT_W-1:0] num_q;
  logic [DEC_W-1:0] dec_cnt;
  logic [DEC_W-1:0] dec_lim;

  logic [CNT_W-1:0] step_inc;
  logic [DEC_W-1:0] dec_inc;
  logic             run_end;
  logic             cap_ok;
  logic             last_step;
  logic             abort_act;
  logic             bound_hit;
  logic             capture;
  logic             flush;

  logic             load_d;
  logic             step_d;
  logic             busy_d;
  logic             done_d;

  assign step_inc  = step_cnt + CNT_W'(1);
  assign dec_inc   = dec_cnt + DEC_W'(1);
  assign run_end   = (step_inc == num_q) || (dec_inc == dec_lim);
  assign cap_ok    = !out_valid || out_ready;
  assign last_step = (step_cnt == num_q);
  assign abort_act = abort && (state inside {S_LOAD, S_RUN, S_CAPT, S_DONE});

`ifdef LORENZ_CTRL_BOUND_CHECK_EN
  localparam logic signed [WIDTH-1:0] NEG_BOUND = -BOUND;

  logic x_out;
  logic y_out;
  logic z_out;

  // Magnitude test done as two signed compares so the most negative word cannot overflow.
  assign x_out     = (x_in >= BOUND) || (x_in <= NEG_BOUND);
  assign y_out     = (y_in >= BOUND) || (y_in <= NEG_BOUND);
  assign z_out     = (z_in >= BOUND) || (z_in <= NEG_BOUND);
  assign bound_hit = (state inside {S_RUN, S_CAPT}) && (x_out || y_out || z_out);
`else
  assign bound_hit = 1'b0;
`endif

  assign capture = (state == S_CAPT) && cap_ok && !abort_act && !bound_hit;
  assign flush   = abort_act || bound_hit;

  // State and control-output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      int_load <= 1'b0;
      int_step <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef LORENZ_CTRL_BOUND_CHECK_EN
      error    <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      int_load <= load_d;
      int_step <= step_d;
      busy     <= busy_d;
      done     <= done_d;
`ifdef LORENZ_CTRL_BOUND_CHECK_EN
      error    <= (state_nxt == S_ERR);
`endif
    end
  end

`ifndef LORENZ_CTRL_BOUND_CHECK_EN
  assign error = 1'b0;
`endif

  // Next-state logic; abort outranks divergence, which outranks capture.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (abort_act)              state_nxt = S_IDLE;
        else if (num_steps == '0)   state_nxt = S_DONE;
        else                        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (abort_act)              state_nxt = S_IDLE;
        else if (bound_hit)         state_nxt = S_ERR;
        else if (run_end)           state_nxt = S_CAPT;
      end
      S_CAPT: begin
        if (abort_act)              state_nxt = S_IDLE;
        else if (bound_hit)         state_nxt = S_ERR;
        else if (cap_ok)            state_nxt = last_step ? S_DONE : S_RUN;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        if (start) state_nxt = S_LOAD;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Control outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    load_d = 1'b0;
    step_d = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_nxt)
      S_LOAD: begin
        load_d = 1'b1;
        busy_d = 1'b1;
      end
      S_RUN: begin
        step_d = 1'b1;
        busy_d = 1'b1;
      end
      S_CAPT: begin
        busy_d = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        load_d = 1'b0;
      end
    endcase
  end

  // Run counters, latched run parameters and the one-deep sample buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_cnt  <= '0;
      dec_cnt   <= '0;
      num_q     <= '0;
      dec_lim   <= DEC_W'(1);
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
      out_idx   <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          step_cnt <= '0;
          dec_cnt  <= '0;
          num_q    <= num_steps;
          dec_lim  <= (decim == '0) ? DEC_W'(1) : decim;
        end
        S_RUN: begin
          step_cnt <= step_inc;
          dec_cnt  <= run_end ? '0 : dec_inc;
        end
        default: begin
          step_cnt <= step_cnt;
        end
      endcase

      if (flush) begin
        out_valid <= 1'b0;
      end else if (capture) begin
        out_valid <= 1'b1;
        out_x     <= x_in;
        out_y     <= y_in;
        out_z     <= z_in;
        out_idx   <= step_cnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lorenz_step_ctrl.sv
// Scoreboard bench for lorenz_step_ctrl: a linear stand-in integrator feeds the DUT,
// expected samples are queued by the stimulus and checked by a handshake monitor.
module tb_lorenz_step_ctrl;

  localparam int unsigned WIDTH = 27;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned DEC_W = 16;

  localparam logic signed [WIDTH-1:0] X0 = 27'sh0100000;
  localparam logic signed [WIDTH-1:0] Y0 = 27'sh0200000;
  localparam logic signed [WIDTH-1:0] Z0 = 27'sh0300000;
  localparam logic signed [WIDTH-1:0] DX = 27'sh0000400;
  localparam logic signed [WIDTH-1:0] DY = 27'sh0000200;
  localparam logic signed [WIDTH-1:0] DZ = 27'sh0000100;
  localparam logic signed [WIDTH-1:0] BIG = 27'sh1F00000;

  typedef struct {
    logic [CNT_W-1:0]        idx;
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] y;
    logic signed [WIDTH-1:0] z;
  } samp_t;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    start;
  logic                    abort;
  logic [CNT_W-1:0]        num_steps;
  logic [DEC_W-1:0]        decim;
  logic signed [WIDTH-1:0] x_in, y_in, z_in;
  logic                    int_load, int_step, out_valid, out_ready;
  logic signed [WIDTH-1:0] out_x, out_y, out_z;
  logic [CNT_W-1:0]        out_idx;
  logic                    busy, done, error;

  logic signed [WIDTH-1:0] xm, ym, zm;
  logic                    force_bound;

  samp_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    step_pulses = 0;
  int    load_pulses = 0;
  int    done_pulses = 0;
  logic  ov_seen = 1'b0;
  logic  done_ov = 1'b0;
  logic [CNT_W-1:0] done_idx = '0;

  lorenz_step_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .num_steps(num_steps), .decim(decim),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .int_load(int_load), .int_step(int_step),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_idx(out_idx),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Stand-in integrator: each step adds a fixed increment.
  always @(posedge clk) begin
    if (int_load) begin
      xm <= X0; ym <= Y0; zm <= Z0;
    end else if (int_step) begin
      xm <= xm + DX; ym <= ym - DY; zm <= zm + DZ;
    end
  end

  assign x_in = force_bound ? BIG : xm;
  assign y_in = ym;
  assign z_in = zm;

  function automatic samp_t exp_samp(input int k);
    samp_t s;
    s.idx = CNT_W'(k);
    s.x   = X0 + WIDTH'(k) * DX;
    s.y   = Y0 - WIDTH'(k) * DY;
    s.z   = Z0 + WIDTH'(k) * DZ;
    return s;
  endfunction

  // Monitor: pulse counters and scoreboard pop on every handshake transfer.
  always @(negedge clk) begin
    if (!reset) begin
      if (int_step) step_pulses++;
      if (int_load) load_pulses++;
      if (out_valid) ov_seen = 1'b1;
      if (done) begin
        done_pulses++;
        done_ov  = out_valid;
        done_idx = out_idx;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sample_unexpected: got idx=%0d, none expected", out_idx);
        end else begin
          samp_t e;
          e = exp_q.pop_front();
          if (out_idx !== e.idx || out_x !== e.x || out_y !== e.y || out_z !== e.z) begin
            errors++;
            $display("FAIL sample: got idx=%0d x=%h y=%h z=%h, want idx=%0d x=%h y=%h z=%h",
                     out_idx, out_x, out_y, out_z, e.idx, e.x, e.y, e.z);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  task automatic push(input int k);
    exp_q.push_back(exp_samp(k));
  endtask

  task automatic start_run(input int n, input int d);
    num_steps = CNT_W'(n);
    decim     = DEC_W'(d);
    start     = 1'b1;
    cyc();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int d0;
    int n;
    d0 = done_pulses;
    n  = 0;
    while (done_pulses == d0 && n < max_cyc) begin
      cyc();
      n++;
    end
    checks++;
    if (done_pulses == d0) begin
      errors++;
      $display("FAIL %s_timeout: got no done in %0d cycles, want done", name, max_cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, l0, d0, s1;
    logic found;
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    num_steps = '0; decim = '0; force_bound = 1'b0;
    repeat (2) cyc();
    check("rst_ctrl", {58'd0, int_load, int_step, out_valid, busy, done, error}, 64'd0);
    check("rst_idx", 64'(out_idx), 64'd0);
    check("rst_data", 64'({out_x, out_y}), 64'd0);
    reset = 1'b0;
    cyc();
    check("rst_first_step", 64'(int_step), 64'd0);

    // 10 steps, decimate by 5, consumer always ready; parameters scrambled mid-run, start while busy.
    out_ready = 1'b1;
    s0 = step_pulses; l0 = load_pulses; d0 = done_pulses;
    push(5); push(10);
    start_run(10, 5);
    check("t1_load_pulse", 64'(int_load), 64'd1);
    cyc();
    num_steps = 32'd7; decim = 16'd2;
    start = 1'b1; cyc(); start = 1'b0;
    wait_done("t1", 60);
    repeat (3) cyc();
    check("t1_steps", 64'(step_pulses - s0), 64'd10);
    check("t1_loads", 64'(load_pulses - l0), 64'd1);
    check("t1_dones", 64'(done_pulses - d0), 64'd1);
    check("t1_done_after_capt", {31'd0, done_ov, done_idx}, {31'd0, 1'b1, 32'd10});
    check("t1_q_empty", 64'(exp_q.size()), 64'd0);

    // Back-pressure: consumer stalled 20 cycles, integrator must stall after step 2.
    out_ready = 1'b0;
    s0 = step_pulses;
    push(1); push(2); push(3); push(4);
    start_run(4, 1);
    repeat (20) cyc();
    check("t2_held_valid", 64'(out_valid), 64'd1);
    check("t2_held_idx", 64'(out_idx), 64'd1);
    check("t2_held_x", 64'(out_x), 64'(exp_samp(1).x));
    check("t2_stall_steps", 64'(step_pulses - s0), 64'd2);
    check("t2_stall_ctrl", {62'd0, int_step, busy}, {62'd0, 1'b0, 1'b1});
    out_ready = 1'b1;
    wait_done("t2", 60);
    repeat (3) cyc();
    check("t2_steps", 64'(step_pulses - s0), 64'd4);
    check("t2_q_empty", 64'(exp_q.size()), 64'd0);

    // Zero-length run.
    ov_seen = 1'b0;
    s0 = step_pulses; l0 = load_pulses;
    start_run(0, 3);
    wait_done("t3", 10);
    repeat (2) cyc();
    check("t3_steps", 64'(step_pulses - s0), 64'd0);
    check("t3_loads", 64'(load_pulses - l0), 64'd1);
    check("t3_no_valid", 64'(ov_seen), 64'd0);

    // decim of zero behaves as one.
    s0 = step_pulses;
    push(1); push(2); push(3);
    start_run(3, 0);
    wait_done("t4", 40);
    repeat (3) cyc();
    check("t4_steps", 64'(step_pulses - s0), 64'd3);
    check("t4_q_empty", 64'(exp_q.size()), 64'd0);

    // Abort during step 7 of a 100-step run with a held sample.
    out_ready = 1'b0;
    s0 = step_pulses; d0 = done_pulses;
    start_run(100, 5);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (int_step && step_pulses == s0 + 6) found = 1'b1;
    end
    check("t5_reach_step7", 64'(found), 64'd1);
    check("t5_held_idx", 64'(out_idx), 64'd5);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("t5_abort_ctrl", {61'd0, int_step, out_valid, busy}, 64'd0);
    repeat (5) cyc();
    check("t5_steps", 64'(step_pulses - s0), 64'd7);
    check("t5_no_done", 64'(done_pulses - d0), 64'd0);
    out_ready = 1'b1;
    push(1); push(2);
    start_run(2, 1);
    check("t5_reload", 64'(int_load), 64'd1);
    wait_done("t5", 30);
    repeat (3) cyc();
    check("t5_q_empty", 64'(exp_q.size()), 64'd0);

    // Reset while a sample is held in CAPT.
    out_ready = 1'b0;
    start_run(4, 1);
    repeat (8) cyc();
    check("t6_pre_valid", {62'd0, out_valid, int_step}, {62'd0, 1'b1, 1'b0});
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_ctrl", {58'd0, int_load, int_step, out_valid, busy, done, error}, 64'd0);
    check("t6_rst_idx", 64'(out_idx), 64'd0);
    check("t6_rst_data", 64'({out_y, out_z}), 64'd0);
    cyc();
    reset = 1'b0;
    cyc();
    check("t6_post_ctrl", {61'd0, int_step, busy, out_valid}, 64'd0);
    out_ready = 1'b1;
    s0 = step_pulses;
    push(1); push(2); push(3);
    start_run(3, 1);
    wait_done("t6", 30);
    repeat (3) cyc();
    check("t6_steps", 64'(step_pulses - s0), 64'd3);
    check("t6_q_empty", 64'(exp_q.size()), 64'd0);

`ifdef LORENZ_CTRL_BOUND_CHECK_EN
    // Divergence: x forced to the limit mid-run.
    s0 = step_pulses;
    start_run(100, 50);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (int_step && step_pulses == s0 + 3) found = 1'b1;
    end
    check("t7_reach_step", 64'(found), 64'd1);
    force_bound = 1'b1;
    cyc();
    check("t7_err", {61'd0, error, int_step, busy}, {61'd0, 1'b1, 1'b0, 1'b0});
    s1 = step_pulses;
    repeat (5) cyc();
    check("t7_steps_stop", 64'(step_pulses - s1), 64'd0);
    check("t7_sticky", 64'(error), 64'd1);
    force_bound = 1'b0;
    push(1); push(2);
    start_run(2, 1);
    check("t7_restart", {62'd0, int_load, error}, {62'd0, 1'b1, 1'b0});
    wait_done("t7", 30);
    repeat (3) cyc();
    check("t7_q_empty", 64'(exp_q.size()), 64'd0);
`else
    check("error_tied_low", 64'(error), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
